// File: rtl/fir_stream_ctrl.sv
// Sample scheduler for the FIR: FIFO-buffered upstream samples feed fir_x one per clock.
// Results come out LAT+2 clocks after acceptance. Upstream stalls on full/FLUSH; no downstream backpressure.
module fir_stream_ctrl #(
   parameter int DW    = 8,
   parameter int YW    = 20,
   parameter int TAPS  = 4,
   parameter int LAT   = 1,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          start,
   input  logic          flush,
   output logic          busy,
   output logic          err_underrun,
   output logic [DW-1:0] fir_x,
   input  logic [YW-1:0] fir_y,
   output logic          m_valid,
   output logic [YW-1:0] m_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int ZW = (TAPS > 2) ? $clog2(TAPS) : 1;
   localparam logic [ZW-1:0] ZLAST = ZW'(TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t        state;
   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wptr, rptr;
   logic          empty, full, push, pop;
   logic [LAT:0]  tag;
   logic          issued;
   logic [ZW-1:0] zcnt;
   logic [DW-1:0] rd_dat;

   // Pointers carry a wrap bit so equal low bits mean empty or full depending on it.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign s_ready = !full && (state != S_FLUSH) && rst_n;
   assign push    = s_valid && s_ready;
   assign pop     = ((state == S_RUN) || (state == S_FLUSH)) && !empty;
   assign rd_dat  = mem[rptr[AW-1:0]];
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         wptr         <= '0;
         rptr         <= '0;
         tag          <= '0;
         issued       <= 1'b0;
         zcnt         <= '0;
         fir_x        <= '0;
         err_underrun <= 1'b0;
         m_valid      <= 1'b0;
         m_data       <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);

         tag[LAT:1] <= tag[LAT-1:0];
         m_valid    <= tag[LAT];
         if (tag[LAT]) m_data <= fir_y;

         case (state)
            S_IDLE: begin
               fir_x  <= '0;
               tag[0] <= 1'b0;
               if (start) begin
                  state        <= S_RUN;
                  err_underrun <= 1'b0;
                  issued       <= 1'b0;
               end
            end
            S_RUN: begin
               if (pop) begin
                  fir_x  <= rd_dat;
                  tag[0] <= 1'b1;
                  issued <= 1'b1;
               end else begin
                  fir_x  <= '0;
                  tag[0] <= 1'b0;
                  if (issued) err_underrun <= 1'b1;
               end
               if (flush) begin
                  state <= S_FLUSH;
                  zcnt  <= '0;
               end
            end
            S_FLUSH: begin
               if (pop) begin
                  fir_x  <= rd_dat;
                  tag[0] <= 1'b1;
               end else if (zcnt != ZLAST) begin
                  // Zero tail pushes the last real samples through every tap.
                  fir_x  <= '0;
                  tag[0] <= 1'b1;
                  zcnt   <= zcnt + ZW'(1);
               end else begin
                  fir_x  <= '0;
                  tag[0] <= 1'b0;
                  if (tag[LAT-1:0] == '0) state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Bench for fir_stream_ctrl with a one-clock pass-through FIR stub and a result scoreboard.
module tb_fir_stream_ctrl;
   localparam int DW = 8;
   localparam int YW = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic          busy;
   logic          err_underrun;
   logic [DW-1:0] fir_x;
   logic [YW-1:0] fir_y;
   logic          m_valid;
   logic [YW-1:0] m_data;

   int checks = 0;
   int errors = 0;
   logic [YW-1:0] exp_q[$];

   always #5 clk = ~clk;

   fir_stream_ctrl #(.DW(DW), .YW(YW), .TAPS(4), .LAT(1), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .start(start), .flush(flush), .busy(busy), .err_underrun(err_underrun),
      .fir_x(fir_x), .fir_y(fir_y), .m_valid(m_valid), .m_data(m_data)
   );

   // FIR stand-in: one clock latency, y is zero-extended x
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) fir_y <= '0;
      else        fir_y <= {{(YW-DW){1'b0}}, fir_x};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_zeros(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && busy; i++) step();
      chk("wait_idle_busy", 32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && m_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_m_valid: got m_data %0d expected no pulse at %0t", m_data, $time);
         end else begin
            chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] pre [4];
      pre[0] = 8'd50; pre[1] = 8'd0; pre[2] = 8'd0; pre[3] = 8'd0;

      // Reset
      #3;
      chk("rst_fir_x", 32'(fir_x), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_err", 32'(err_underrun), 32'd0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rel_s_ready", 32'(s_ready), 32'd1);
      chk("rel_busy", 32'(busy), 32'd0);

      // Single sample
      start = 1'b1; step(); start = 1'b0;
      s_valid = 1'b1; s_data = 8'd50; exp_q.push_back(20'd50);
      step();
      s_valid = 1'b0;
      chk("single_fir_x_h", 32'(fir_x), 32'd0);
      step();
      chk("single_fir_x_h1", 32'(fir_x), 32'd50);
      chk("single_busy", 32'(busy), 32'd1);
      step();
      chk("single_m_valid_h2", 32'(m_valid), 32'd0);
      step();
      chk("single_m_valid_h3", 32'(m_valid), 32'd1);
      chk("single_m_data_h3", 32'(m_data), 32'd50);
      step();
      chk("single_m_valid_h4", 32'(m_valid), 32'd0);
      flush = 1'b1; step(); flush = 1'b0;
      exp_zeros(3);
      wait_idle();

      // Prefill in IDLE
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = pre[i]; exp_q.push_back(20'(pre[i]));
         step();
      end
      s_valid = 1'b0;
      chk("prefill_full_s_ready", 32'(s_ready), 32'd0);
      start = 1'b1; step(); start = 1'b0;
      chk("prefill_err_cleared", 32'(err_underrun), 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) flush = 1'b1;
         step();
         chk("prefill_fir_x", 32'(fir_x), 32'(pre[i]));
      end
      flush = 1'b0;
      chk("prefill_flush_s_ready", 32'(s_ready), 32'd0);
      exp_zeros(3);
      wait_idle();
      chk("prefill_err", 32'(err_underrun), 32'd0);

      // Underrun
      start = 1'b1; step(); start = 1'b0;
      s_valid = 1'b1; s_data = 8'd20; exp_q.push_back(20'd20);
      step();
      s_valid = 1'b0;
      step(); chk("under_fir_x0", 32'(fir_x), 32'd20);
      step(); chk("under_fir_x1", 32'(fir_x), 32'd0);
      s_valid = 1'b1; s_data = 8'd30; exp_q.push_back(20'd30);
      step(); chk("under_fir_x2", 32'(fir_x), 32'd0);
      s_valid = 1'b0;
      step(); chk("under_fir_x3", 32'(fir_x), 32'd30);
      chk("under_err_set", 32'(err_underrun), 32'd1);
      flush = 1'b1; step(); flush = 1'b0;
      exp_zeros(3);
      wait_idle();
      chk("under_err_sticky", 32'(err_underrun), 32'd1);
      start = 1'b1; step(); start = 1'b0;
      chk("under_err_cleared", 32'(err_underrun), 32'd0);

      // Flush with zero tail
      s_valid = 1'b1; s_data = 8'd50; exp_q.push_back(20'd50);
      step();
      exp_q.push_back(20'd50);
      step();
      chk("flush_fir_x0", 32'(fir_x), 32'd50);
      s_valid = 1'b0; flush = 1'b1;
      exp_zeros(3);
      step();
      flush = 1'b0;
      chk("flush_fir_x1", 32'(fir_x), 32'd50);
      chk("flush_s_ready", 32'(s_ready), 32'd0);
      start = 1'b1; flush = 1'b1;
      step();
      start = 1'b0; flush = 1'b0;
      chk("flush_fir_x2", 32'(fir_x), 32'd0);
      chk("flush_busy_ignore", 32'(busy), 32'd1);
      step(); chk("flush_fir_x3", 32'(fir_x), 32'd0);
      step(); chk("flush_fir_x4", 32'(fir_x), 32'd0);
      step(); chk("flush_busy_before_last", 32'(busy), 32'd1);
      step();
      chk("flush_busy_last", 32'(busy), 32'd0);
      chk("flush_m_valid_last", 32'(m_valid), 32'd1);
      chk("flush_m_data_last", 32'(m_data), 32'd0);
      chk("flush_idle_s_ready", 32'(s_ready), 32'd1);

      // Reset during the zero tail
      start = 1'b1; step(); start = 1'b0;
      s_valid = 1'b1; s_data = 8'd60; exp_q.push_back(20'd60);
      step();
      s_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      step(); step();
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_fir_x", 32'(fir_x), 32'd0);
      chk("midrst_m_valid", 32'(m_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_s_ready", 32'(s_ready), 32'd0);
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("midrst_rel_s_ready", 32'(s_ready), 32'd1);
      start = 1'b1; step(); start = 1'b0;
      s_valid = 1'b1; s_data = 8'd70; exp_q.push_back(20'd70);
      step();
      s_valid = 1'b0;
      step(); chk("midrst_fir_x70", 32'(fir_x), 32'd70);
      step();
      step();
      chk("midrst_m_valid70", 32'(m_valid), 32'd1);
      chk("midrst_m_data70", 32'(m_data), 32'd70);
      flush = 1'b1; step(); flush = 1'b0;
      exp_zeros(3);
      wait_idle();
      step(); step(); step();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
